// File: rtl/mouse_pos_tracker_if.sv
// Mouse tracker bus: PS/2 byte receiver input and cursor/button outputs.
// master = byte source / position consumer, slave = mouse_pos_tracker.
interface mouse_pos_tracker_if;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic [11:0] xpos;
  logic [11:0] ypos;
  logic        left;
  logic        right;
  logic        pkt_done;
  logic        left_click;
  logic        right_click;

  modport master (
    output rx_data, rx_valid,
    input  xpos, ypos, left, right, pkt_done, left_click, right_click
  );

  modport slave (
    input  rx_data, rx_valid,
    output xpos, ypos, left, right, pkt_done, left_click, right_click
  );
endinterface

// File: rtl/mouse_pos_tracker.sv
// PS/2 mouse packet assembler and absolute cursor tracker.
// Builds 3-byte packets (status, X, Y), accumulates the signed deltas into
// clamped 12-bit screen coordinates and exports the button levels.
// Optional macro MOUSE_CLICK_PULSE_EN adds one-cycle press pulses on
// left_click/right_click; without it those outputs are tied low.
module mouse_pos_tracker #(
  parameter int XMAX        = 1023,
  parameter int YMAX        = 767,
  parameter int TIMEOUT_CYC = 100000
) (
  input logic               clk,
  input logic               rst,
  mouse_pos_tracker_if.slave io_bus
);
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  typedef enum logic [1:0] {B0 = 2'd0, B1 = 2'd1, B2 = 2'd2} state_t;

  state_t              r_state, w_next;
  logic [CW-1:0]       r_cnt;
  logic                r_l, r_r, r_xs, r_ys, r_xo, r_yo;
  logic [7:0]          r_xb;
  logic [11:0]         r_xpos, r_ypos;
  logic                r_left, r_right, r_done;
  logic                w_timeout, w_apply;
  logic signed [13:0]  w_nx, w_ny;
  logic [11:0]         w_xc, w_yc;

  // A byte arriving on the last idle cycle wins over the timeout.
  assign w_timeout = (r_state != B0) && !io_bus.rx_valid &&
                     (r_cnt == CW'(TIMEOUT_CYC - 1));

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= B0;
    else     r_state <= w_next;
  end

  // Next state: advance one byte per rx_valid, B0 only accepts status bytes (bit3 set).
  always_comb begin
    w_next = r_state;
    if (w_timeout) begin
      w_next = B0;
    end else if (io_bus.rx_valid) begin
      case (r_state)
        B0:      if (io_bus.rx_data[3]) w_next = B1;
        B1:      w_next = B2;
        B2:      w_next = B0;
        default: w_next = B0;
      endcase
    end
  end

  // Apply strobe and clamped candidate positions; Y byte is taken live from the bus.
  always_comb begin
    w_apply = (r_state == B2) && io_bus.rx_valid;
    w_nx    = $signed({2'b00, r_xpos}) + $signed({{5{r_xs}}, r_xs, r_xb});
    // PS/2 +Y is up, screen +y is down.
    w_ny    = $signed({2'b00, r_ypos}) - $signed({{5{r_ys}}, r_ys, io_bus.rx_data});
    if (w_nx[13])                        w_xc = '0;
    else if (w_nx[12:0] > 13'(XMAX))     w_xc = 12'(XMAX);
    else                                 w_xc = w_nx[11:0];
    if (w_ny[13])                        w_yc = '0;
    else if (w_ny[12:0] > 13'(YMAX))     w_yc = 12'(YMAX);
    else                                 w_yc = w_ny[11:0];
  end

  // Latch status and X bytes while the packet is assembled.
  always_ff @(posedge clk) begin
    if (rst) begin
      {r_l, r_r, r_xs, r_ys, r_xo, r_yo} <= '0;
      r_xb <= '0;
    end else if (io_bus.rx_valid) begin
      if (r_state == B0 && io_bus.rx_data[3]) begin
        r_l  <= io_bus.rx_data[0];
        r_r  <= io_bus.rx_data[1];
        r_xs <= io_bus.rx_data[4];
        r_ys <= io_bus.rx_data[5];
        r_xo <= io_bus.rx_data[6];
        r_yo <= io_bus.rx_data[7];
      end
      if (r_state == B1) r_xb <= io_bus.rx_data;
    end
  end

  // Mid-packet idle counter; cleared by any byte, in B0, or when it fires.
  always_ff @(posedge clk) begin
    if (rst || r_state == B0 || io_bus.rx_valid || w_timeout) r_cnt <= '0;
    else                                                       r_cnt <= r_cnt + CW'(1);
  end

  // Position/button registers, updated on the edge that samples the Y byte.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_xpos  <= 12'(XMAX >> 1);
      r_ypos  <= 12'(YMAX >> 1);
      r_left  <= 1'b0;
      r_right <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_done <= w_apply;
      if (w_apply) begin
        if (!r_xo) r_xpos <= w_xc;
        if (!r_yo) r_ypos <= w_yc;
        r_left  <= r_l;
        r_right <= r_r;
      end
    end
  end

`ifdef MOUSE_CLICK_PULSE_EN
  logic r_lclick, r_rclick;

  // Press pulses: rising edge of the button level across packet applies.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_lclick <= 1'b0;
      r_rclick <= 1'b0;
    end else begin
      r_lclick <= w_apply & r_l & ~r_left;
      r_rclick <= w_apply & r_r & ~r_right;
    end
  end

  assign io_bus.left_click  = r_lclick;
  assign io_bus.right_click = r_rclick;
`else
  assign io_bus.left_click  = 1'b0;
  assign io_bus.right_click = 1'b0;
`endif

  assign io_bus.xpos     = r_xpos;
  assign io_bus.ypos     = r_ypos;
  assign io_bus.left     = r_left;
  assign io_bus.right    = r_right;
  assign io_bus.pkt_done = r_done;

endmodule

// File: tb/tb_mouse_pos_tracker.sv
// Bench for mouse_pos_tracker: directed plan steps plus randomized byte
// streams checked against a packet-level reference model (byte queue,
// integer arithmetic, clamping).
module tb_mouse_pos_tracker;
  localparam int XMAX = 1023;
  localparam int YMAX = 767;
  localparam int TO   = 20;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mouse_pos_tracker_if bus ();

  mouse_pos_tracker #(.XMAX(XMAX), .YMAX(YMAX), .TIMEOUT_CYC(TO)) dut (
    .clk    (clk),
    .rst    (rst),
    .io_bus (bus)
  );

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [7:0] q[$];
  int ex, ey, idle_run;
  bit el, er, exp_done, exp_lc, exp_rc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic check_all(input string tag);
    chk({tag, " xpos"},        32'(bus.xpos),        32'(ex));
    chk({tag, " ypos"},        32'(bus.ypos),        32'(ey));
    chk({tag, " left"},        32'(bus.left),        32'(el));
    chk({tag, " right"},       32'(bus.right),       32'(er));
    chk({tag, " pkt_done"},    32'(bus.pkt_done),    32'(exp_done));
    chk({tag, " left_click"},  32'(bus.left_click),  32'(exp_lc));
    chk({tag, " right_click"}, 32'(bus.right_click), 32'(exp_rc));
  endtask

  function automatic int clampi(input int v, input int hi);
    return (v < 0) ? 0 : (v > hi) ? hi : v;
  endfunction

  task automatic model_byte(input logic [7:0] b);
    logic [7:0] s;
    int dx, dy;
    exp_done = 0; exp_lc = 0; exp_rc = 0; idle_run = 0;
    if (q.size() == 0 && !b[3]) return;
    q.push_back(b);
    if (q.size() == 3) begin
      s  = q[0];
      dx = s[4] ? int'(q[1]) - 256 : int'(q[1]);
      dy = s[5] ? int'(q[2]) - 256 : int'(q[2]);
      if (!s[6]) ex = clampi(ex + dx, XMAX);
      if (!s[7]) ey = clampi(ey - dy, YMAX);
`ifdef MOUSE_CLICK_PULSE_EN
      exp_lc = s[0] && !el;
      exp_rc = s[1] && !er;
`endif
      el = s[0];
      er = s[1];
      exp_done = 1;
      q.delete();
    end
  endtask

  task automatic send(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'($urandom);
    model_byte(b);
    check_all("byte");
  endtask

  task automatic send3(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
    send(a); send(b); send(c);
  endtask

  task automatic idle(input int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
      exp_done = 0; exp_lc = 0; exp_rc = 0;
      if (q.size() != 0) begin
        idle_run += n;
        if (idle_run >= TO) q.delete();
      end
      check_all("idle");
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.rx_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    ex = XMAX / 2; ey = YMAX / 2; el = 0; er = 0;
    exp_done = 0; exp_lc = 0; exp_rc = 0; idle_run = 0;
    q.delete();
    check_all("reset");
  endtask

  initial begin
    logic [7:0] b;
    int gap;
    bus.rx_data  = 8'h00;
    bus.rx_valid = 1'b0;
    repeat (2) @(posedge clk);

    // reset state
    do_reset();
    chk("reset xpos 511", 32'(bus.xpos), 32'd511);
    chk("reset ypos 383", 32'(bus.ypos), 32'd383);

    // basic packet
    send3(8'h08, 8'h0A, 8'h05);
    chk("basic xpos 521", 32'(bus.xpos), 32'd521);
    chk("basic ypos 378", 32'(bus.ypos), 32'd378);
    chk("basic pkt_done", 32'(bus.pkt_done), 32'd1);
    idle(1);

    // clamp at left edge and bottom edge
    do_reset();
    send3(8'h18, 8'h00, 8'h00);
    chk("clamp x 255", 32'(bus.xpos), 32'd255);
    send3(8'h18, 8'h00, 8'h00);
    chk("clamp x 0a", 32'(bus.xpos), 32'd0);
    send3(8'h18, 8'h00, 8'h00);
    chk("clamp x 0b", 32'(bus.xpos), 32'd0);
    send3(8'h28, 8'h00, 8'h00);
    chk("clamp y 639", 32'(bus.ypos), 32'd639);
    send3(8'h28, 8'h00, 8'h00);
    chk("clamp y 767", 32'(bus.ypos), 32'd767);

    // resync on junk byte, then X overflow
    do_reset();
    send(8'h00);
    send3(8'h08, 8'h04, 8'h00);
    chk("resync x 515", 32'(bus.xpos), 32'd515);
    send3(8'h48, 8'h7F, 8'h00);
    chk("xovf x 515", 32'(bus.xpos), 32'd515);

    // timeout drops the partial packet
    do_reset();
    send(8'h08); send(8'h10);
    idle(TO);
    send3(8'h09, 8'h00, 8'h00);
    chk("timeout x", 32'(bus.xpos), 32'd511);
    chk("timeout left", 32'(bus.left), 32'd1);

    // byte on the last idle cycle is accepted
    do_reset();
    send(8'h08); send(8'h10);
    idle(TO - 1);
    send(8'h05);
    chk("edge x 527", 32'(bus.xpos), 32'd527);

    // reset mid-packet
    send(8'h08); send(8'h20);
    do_reset();
    send(8'h01);
    send3(8'h0A, 8'h01, 8'h01);

    // click pulses
    do_reset();
    send3(8'h09, 8'h00, 8'h00);
    send3(8'h09, 8'h00, 8'h00);
    send3(8'h08, 8'h00, 8'h00);
    chk("click left off", 32'(bus.left), 32'd0);

    // randomized streams
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if (q.size() == 0) begin
        b = 8'($urandom);
        if ($urandom_range(0, 7) != 0) b[7:6] = 2'b00;
        if ($urandom_range(0, 7) != 0) b[3] = 1'b1;
      end else begin
        b = 8'($urandom);
      end
      send(b);
      if ($urandom_range(0, 3) == 0) begin
        case ($urandom_range(0, 5))
          0:       gap = TO - 1;
          1:       gap = TO;
          default: gap = $urandom_range(1, 4);
        endcase
        idle(gap);
      end
      if ($urandom_range(0, 199) == 0) do_reset();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mouse_pos_tracker.md
Name: mouse_pos_tracker

Overview:
- Source end of the mouse-position path: assembles 3-byte PS/2 mouse packets from the byte receiver.
- Accumulates the signed X/Y deltas into absolute 12-bit screen coordinates, clamped to the display area.
- Outputs button levels. The xpos/ypos outputs feed the position synchroniser and cursor/field logic.

Parameters:
- XMAX, 1023, largest legal x coordinate (inclusive)
- YMAX, 767, largest legal y coordinate (inclusive)
- TIMEOUT_CYC, 100000, idle clk cycles mid-packet before the assembler resynchronises

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous active-high reset
- rx_data  input  8  received PS/2 byte
- rx_valid  input  1  one-cycle strobe, rx_data valid
- xpos  output  12  absolute cursor x, 0..XMAX
- ypos  output  12  absolute cursor y, 0..YMAX, 0 = top of screen
- left  output  1  left button level
- right  output  1  right button level
- pkt_done  output  1  one-cycle pulse when a packet is applied
- left_click  output  1  left press pulse (optional feature)
- right_click  output  1  right press pulse (optional feature)

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst), sampled on the rising edge of clk.
- Reset values:
  - xpos = XMAX>>1 (511), ypos = YMAX>>1 (383).
  - left = right = 0; pkt_done = left_click = right_click = 0.
  - State = B0; timeout counter = 0.
- FSM states B0, B1, B2. Transitions happen only on edges where rx_valid = 1, except for timeout.
  - B0: if rx_data[3] = 1, latch status byte (L = bit0, R = bit1, Xsign = bit4, Ysign = bit5, Xovf = bit6, Yovf = bit7) and go to B1. If rx_data[3] = 0, discard the byte and stay in B0 (resync).
  - B1: latch X low byte and go to B2.
  - B2: latch Y low byte, apply the packet and go to B0.
- Apply, registered on the edge that samples byte 2; outputs are visible the following cycle:
  - dx = {Xsign, Xbyte} and dy = {Ysign, Ybyte}, each 9-bit two's complement (range -256..255).
  - nx = xpos + dx, computed 14-bit signed. If nx < 0, xpos = 0; if nx > XMAX, xpos = XMAX; otherwise xpos = nx.
  - ny = ypos - dy (PS/2 +Y is up, screen +y is down). Clamp to 0..YMAX the same way.
  - If Xovf = 1, xpos is unchanged. If Yovf = 1, ypos is unchanged. Buttons are updated regardless of overflow.
  - left and right take L and R; pkt_done = 1 for exactly that one cycle.
- Timeout:
  - The counter increments each cycle in B1 or B2 with rx_valid = 0, and clears on rx_valid or in B0.
  - When the counter reaches TIMEOUT_CYC - 1 with no rx_valid, state returns to B0 and the partial packet is dropped; outputs are unchanged.
  - If rx_valid coincides with the timeout cycle, the byte is accepted normally and no timeout occurs.
- Reset mid-packet: partial packet discarded, all reset values restored.
- rx_valid asserted on consecutive cycles is legal; one byte is consumed per cycle.

Optional Feature:
- Macro: MOUSE_CLICK_PULSE_EN.
- Defined: on the apply edge, left_click = L & ~left_prev and right_click = R & ~right_prev, where left_prev/right_prev are the button levels before the apply. Each is high for one cycle, coincident with pkt_done. A press held across multiple packets produces a single pulse.
- Undefined: left_click and right_click are tied to 0; no extra registers are inferred.

Test Plan:
- Reset, no input -> xpos = 511, ypos = 383, left = right = pkt_done = 0.
- Packet 0x08, 0x0A, 0x05 -> next cycle xpos = 521, ypos = 378; one pkt_done pulse.
- Clamp: packet 0x18, 0x00, 0x00 (dx = -256) applied 3 times from reset -> xpos = 255, then 0, then 0. Packet 0x28, 0x00, 0x00 (dy = -256) applied twice -> ypos = 639, then 767.
- Resync: bytes 0x00, 0x08, 0x04, 0x00 -> first byte discarded; packet applied with dx = 4 -> xpos = 515. X overflow: packet 0x48, 0x7F, 0x00 -> xpos unchanged.
- Timeout: 0x08, 0x10, then idle TIMEOUT_CYC cycles, then 0x09, 0x00, 0x00 -> no position change; left = 1 after the third byte.
- With MOUSE_CLICK_PULSE_EN: packets with status 0x09, 0x09, 0x08 -> left_click pulses once, on the first packet only; left returns to 0 after the third. Without the macro, left_click stays 0 throughout.
